// File: rtl/lpif_pkg.sv
// Shared definitions for the LPIF RX link sequencer: LPIF state encodings,
// the sequencer FSM state type and the per-byte framing error codes.
package lpif_pkg;

    // LPIF state encodings as seen on pl_state_sts / lp_state_req
    localparam logic [3:0] LPIF_RESET     = 4'h0;
    localparam logic [3:0] LPIF_ACTIVE    = 4'h1;
    localparam logic [3:0] LPIF_LINKERROR = 4'hA;
    localparam logic [3:0] LPIF_RETRAIN   = 4'hB;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_ACTIVE,
        ST_STALL,
        ST_RETRAIN,
        ST_LINKERROR
    } fsm_state_e;

    // Framing error classification of a single valid byte slot
    localparam logic [2:0] FERR_NONE          = 3'd0;
    localparam logic [2:0] FERR_START_IN_PKT  = 3'd1;
    localparam logic [2:0] FERR_TLPEND_NO_TLP = 3'd2;
    localparam logic [2:0] FERR_DLLPEND_NO_DL = 3'd3;
    localparam logic [2:0] FERR_START_END_SAM = 3'd4;

    // Classify one valid byte against the current tracker state
    function automatic logic [2:0] frame_err_code(
        input logic in_tlp,
        input logic in_dllp,
        input logic tlp_s,
        input logic dllp_s,
        input logic tlp_e,
        input logic edb,
        input logic dllp_e
    );
        logic any_s;
        logic any_e;
        any_s = tlp_s | dllp_s;
        any_e = tlp_e | edb | dllp_e;
        if (any_s && any_e)               return FERR_START_END_SAM;
        if (any_s && (in_tlp || in_dllp)) return FERR_START_IN_PKT;
        if ((tlp_e || edb) && !in_tlp)    return FERR_TLPEND_NO_TLP;
        if (dllp_e && !in_dllp)           return FERR_DLLPEND_NO_DL;
        return FERR_NONE;
    endfunction

endpackage

// File: rtl/lpif_rx_framing_checker.sv
// Per-cycle TLP/DLLP framing scan over the RX marker vectors. Holds the
// in_tlp / in_dllp tracker across cycles and flags any cycle with an error.
module lpif_rx_framing_checker
    import lpif_pkg::*;
#(
    parameter int unsigned LANES_B = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               en,
    input  logic [LANES_B-1:0] rx_valid,
    input  logic [LANES_B-1:0] rx_tlpstart,
    input  logic [LANES_B-1:0] rx_tlpend,
    input  logic [LANES_B-1:0] rx_edb,
    input  logic [LANES_B-1:0] rx_dllpstart,
    input  logic [LANES_B-1:0] rx_dllpend,
    output logic               err_cycle
);

    logic       in_tlp_q, in_tlp_d;
    logic       in_dllp_q, in_dllp_d;
    logic       tlp_v, dllp_v, err_v;
    logic [2:0] code;

    // Byte-ordered scan; an error clears the tracker and the scan continues idle
    always_comb begin
        tlp_v  = in_tlp_q;
        dllp_v = in_dllp_q;
        err_v  = 1'b0;
        code   = FERR_NONE;
        for (int unsigned i = 0; i < LANES_B; i++) begin
            if (rx_valid[i]) begin
                code = frame_err_code(tlp_v, dllp_v, rx_tlpstart[i], rx_dllpstart[i],
                                      rx_tlpend[i], rx_edb[i], rx_dllpend[i]);
                if (code != FERR_NONE) begin
                    err_v  = 1'b1;
                    tlp_v  = 1'b0;
                    dllp_v = 1'b0;
                end else begin
                    if (rx_tlpstart[i])              tlp_v  = 1'b1;
                    if (rx_dllpstart[i])             dllp_v = 1'b1;
                    if (rx_tlpend[i] || rx_edb[i])   tlp_v  = 1'b0;
                    if (rx_dllpend[i])               dllp_v = 1'b0;
                end
            end
        end
        err_cycle = en & err_v;
        in_tlp_d  = in_tlp_q;
        in_dllp_d = in_dllp_q;
        if (clr) begin
            in_tlp_d  = 1'b0;
            in_dllp_d = 1'b0;
        end else if (en) begin
            in_tlp_d  = tlp_v;
            in_dllp_d = dllp_v;
        end
    end

    // Tracker registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_tlp_q  <= 1'b0;
            in_dllp_q <= 1'b0;
        end else begin
            in_tlp_q  <= in_tlp_d;
            in_dllp_q <= in_dllp_d;
        end
    end

endmodule

// File: rtl/lpif_rx_link_sequencer.sv
// LPIF RX link sequencer: LPIF state machine, stall handshake, shared
// STALL/RETRAIN timeout timer, framing error counter and RX datapath gate.
module lpif_rx_link_sequencer
    import lpif_pkg::*;
#(
    parameter int unsigned LANES_B     = 64,
    parameter int unsigned STALL_TMO   = 1024,
    parameter int unsigned RETRAIN_TMO = 65535,
    parameter int unsigned ERR_LIMIT   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               link_up,
    input  logic               ltssm_l0,
    input  logic               ltssm_recov,
    input  logic               speed_change,
    input  logic [3:0]         lp_state_req,
    input  logic               lp_stallack,
    input  logic [LANES_B-1:0] rx_valid,
    input  logic [LANES_B-1:0] rx_tlpstart,
    input  logic [LANES_B-1:0] rx_tlpend,
    input  logic [LANES_B-1:0] rx_edb,
    input  logic [LANES_B-1:0] rx_dllpstart,
    input  logic [LANES_B-1:0] rx_dllpend,
    output logic [3:0]         pl_state_sts,
    output logic               pl_stallreq,
    output logic               rx_gate_en,
    output logic               pl_error,
    output logic [15:0]        err_count
);

    // Timer holds its last-cycle index: leaving cycle N of a state means timer_q == N-1
    localparam logic [15:0] STALL_LAST   = 16'(STALL_TMO - 1);
    localparam logic [15:0] RETRAIN_LAST = 16'(RETRAIN_TMO - 1);
    localparam logic [15:0] ERR_LIMIT_W  = 16'(ERR_LIMIT);

    fsm_state_e  state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] err_count_q, err_count_d;
    logic [3:0]  sts_q, sts_d;
    logic        stallreq_q, stallreq_d;
    logic        gate_q, gate_d;
    logic        pl_error_q, pl_error_d;
    logic        err_cycle;
    logic        trk_clr;

    lpif_rx_framing_checker #(
        .LANES_B (LANES_B)
    ) u_framing (
        .clk          (clk),
        .reset        (reset),
        .clr          (trk_clr),
        .en           (gate_q),
        .rx_valid     (rx_valid),
        .rx_tlpstart  (rx_tlpstart),
        .rx_tlpend    (rx_tlpend),
        .rx_edb       (rx_edb),
        .rx_dllpstart (rx_dllpstart),
        .rx_dllpend   (rx_dllpend),
        .err_cycle    (err_cycle)
    );

    // Next state, with link loss overriding every other transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:
                if (ltssm_l0 && lp_state_req == LPIF_ACTIVE) state_d = ST_ACTIVE;
            ST_ACTIVE:
                if (err_count_q >= ERR_LIMIT_W)         state_d = ST_LINKERROR;
                else if (speed_change || ltssm_recov)   state_d = ST_STALL;
            ST_STALL:
                if (lp_stallack)                        state_d = ST_RETRAIN;
                else if (timer_q >= STALL_LAST)         state_d = ST_LINKERROR;
            ST_RETRAIN:
                if (ltssm_l0 && !ltssm_recov)           state_d = ST_ACTIVE;
                else if (timer_q >= RETRAIN_LAST)       state_d = ST_LINKERROR;
            ST_LINKERROR:
                if (lp_state_req == LPIF_RESET)         state_d = ST_RESET;
            default:                                    state_d = ST_RESET;
        endcase
        if (!link_up && state_q != ST_RESET) state_d = ST_RESET;
    end

    // Registered-output values, timer and error counter derived from the next state
    always_comb begin
        trk_clr = (state_d == ST_RESET);

        if (state_d != state_q)
            timer_d = '0;
        else if (state_q == ST_STALL || state_q == ST_RETRAIN)
            timer_d = timer_q + 16'd1;
        else
            timer_d = '0;

        err_count_d = err_count_q;
        if (state_q == ST_LINKERROR && state_d == ST_RESET)
            err_count_d = '0;
        else if (err_cycle && err_count_q != 16'hFFFF)
            err_count_d = err_count_q + 16'd1;

        case (state_d)
            ST_ACTIVE, ST_STALL: sts_d = LPIF_ACTIVE;
            ST_RETRAIN:          sts_d = LPIF_RETRAIN;
            ST_LINKERROR:        sts_d = LPIF_LINKERROR;
            default:             sts_d = LPIF_RESET;
        endcase

        stallreq_d = (state_d == ST_STALL) || (state_d == ST_RETRAIN);
        gate_d     = (state_d == ST_ACTIVE) || (state_d == ST_STALL);
        pl_error_d = err_cycle;
    end

    // FSM state, timer, counter and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RESET;
            timer_q     <= '0;
            err_count_q <= '0;
            sts_q       <= LPIF_RESET;
            stallreq_q  <= 1'b0;
            gate_q      <= 1'b0;
            pl_error_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            err_count_q <= err_count_d;
            sts_q       <= sts_d;
            stallreq_q  <= stallreq_d;
            gate_q      <= gate_d;
            pl_error_q  <= pl_error_d;
        end
    end

    assign pl_state_sts = sts_q;
    assign pl_stallreq  = stallreq_q;
    assign rx_gate_en   = gate_q;
    assign pl_error     = pl_error_q;
    assign err_count    = err_count_q;

endmodule

// File: tb/tb_lpif_rx_link_sequencer.sv
// Directed, table-driven bench for lpif_rx_link_sequencer with hand-written
// sequences for stall timeout, link loss and asynchronous reset.
module tb_lpif_rx_link_sequencer;

    localparam int unsigned LANES_B   = 64;
    localparam int unsigned STALL_TMO = 1024;
    localparam logic [63:0] A = '1;
    localparam logic [63:0] Z = '0;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic               clk = 1'b0;
    logic               reset;
    logic               link_up, ltssm_l0, ltssm_recov, speed_change, lp_stallack;
    logic [3:0]         lp_state_req;
    logic [LANES_B-1:0] rx_valid, rx_tlpstart, rx_tlpend, rx_edb, rx_dllpstart, rx_dllpend;
    logic [3:0]         pl_state_sts;
    logic               pl_stallreq, rx_gate_en, pl_error;
    logic [15:0]        err_count;

    int total = 0;
    int pass  = 0;

    typedef struct {
        logic        lu, l0, rc, sc;
        logic [3:0]  req;
        logic        ack;
        logic [63:0] vld, ts, te, edb, ds, de;
        logic [3:0]  s;
        logic        st, g, er;
        logic [15:0] c;
    } vec_t;

    vec_t vecs[$];

    lpif_rx_link_sequencer #(
        .LANES_B   (LANES_B),
        .STALL_TMO (STALL_TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .link_up      (link_up),
        .ltssm_l0     (ltssm_l0),
        .ltssm_recov  (ltssm_recov),
        .speed_change (speed_change),
        .lp_state_req (lp_state_req),
        .lp_stallack  (lp_stallack),
        .rx_valid     (rx_valid),
        .rx_tlpstart  (rx_tlpstart),
        .rx_tlpend    (rx_tlpend),
        .rx_edb       (rx_edb),
        .rx_dllpstart (rx_dllpstart),
        .rx_dllpend   (rx_dllpend),
        .pl_state_sts (pl_state_sts),
        .pl_stallreq  (pl_stallreq),
        .rx_gate_en   (rx_gate_en),
        .pl_error     (pl_error),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] b(input int unsigned i);
        return 64'd1 << i;
    endfunction

    function automatic vec_t mk(
        input logic lu, input logic l0, input logic rc, input logic sc,
        input logic [3:0] req, input logic ack,
        input logic [63:0] vld, input logic [63:0] ts, input logic [63:0] te,
        input logic [63:0] edb, input logic [63:0] ds, input logic [63:0] de,
        input logic [3:0] s, input logic st, input logic g, input logic er,
        input logic [15:0] c
    );
        vec_t t;
        t.lu = lu; t.l0 = l0; t.rc = rc; t.sc = sc; t.req = req; t.ack = ack;
        t.vld = vld; t.ts = ts; t.te = te; t.edb = edb; t.ds = ds; t.de = de;
        t.s = s; t.st = st; t.g = g; t.er = er; t.c = c;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        link_up = t.lu; ltssm_l0 = t.l0; ltssm_recov = t.rc; speed_change = t.sc;
        lp_state_req = t.req; lp_stallack = t.ack;
        rx_valid = t.vld; rx_tlpstart = t.ts; rx_tlpend = t.te;
        rx_edb = t.edb; rx_dllpstart = t.ds; rx_dllpend = t.de;
    endtask

    task automatic idle_in();
        drive(mk(H, H, L, L, 4'h1, L, A, Z, Z, Z, Z, Z, 4'h0, L, L, L, 16'd0));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int id, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s step %0d: got %h, expected %h", nm, id, act, exp);
    endtask

    task automatic chk_all(input int id, input logic [3:0] s, input logic st, input logic g,
                           input logic er, input logic [15:0] c);
        chk("pl_state_sts", id, {12'h0, pl_state_sts}, {12'h0, s});
        chk("pl_stallreq",  id, {15'h0, pl_stallreq},  {15'h0, st});
        chk("rx_gate_en",   id, {15'h0, rx_gate_en},   {15'h0, g});
        chk("pl_error",     id, {15'h0, pl_error},     {15'h0, er});
        chk("err_count",    id, err_count, c);
    endtask

    initial begin
        // lu l0 rc sc req ack | vld ts te edb ds de | sts stall gate err cnt
        vecs.push_back(mk(H,H,L,L,4'h1,L, A,Z,Z,Z,Z,Z,                 4'h1,L,H,L,16'd0)); // enter ACTIVE
        vecs.push_back(mk(H,H,L,L,4'h1,L, A,b(0),Z,Z,Z,Z,              4'h1,L,H,L,16'd0)); // TLP opens
        vecs.push_back(mk(H,H,L,L,4'h1,L, A,Z,b(20),Z,b(24),b(31),     4'h1,L,H,L,16'd0)); // TLP close, DLLP
        for (int k = 1; k <= 8; k++)                                                       // orphan tlpend x8
            vecs.push_back(mk(H,H,L,L,4'h1,L, A,Z,(k == 1) ? (b(5) | b(9)) : b(5),Z,Z,Z,
                              4'h1,L,H,H,16'(k)));
        vecs.push_back(mk(H,H,L,L,4'h1,L, A,Z,b(5),Z,Z,Z,              4'hA,L,L,H,16'd9)); // limit + error
        vecs.push_back(mk(H,H,L,L,4'h0,L, A,Z,b(5),Z,Z,Z,              4'h0,L,L,L,16'd0)); // LINKERROR->RESET
        vecs.push_back(mk(H,H,L,L,4'h1,L, A,Z,Z,Z,Z,Z,                 4'h1,L,H,L,16'd0)); // back to ACTIVE
        vecs.push_back(mk(H,H,L,L,4'h1,L, ~b(3),Z,b(3),Z,Z,Z,          4'h1,L,H,L,16'd0)); // invalid slot
        vecs.push_back(mk(H,H,L,L,4'h1,L, A,b(2),b(2),Z,Z,Z,           4'h1,L,H,H,16'd1)); // start+end same byte
        vecs.push_back(mk(H,H,L,L,4'h1,L, A,b(0),b(10),Z,Z,Z,          4'h1,L,H,L,16'd1)); // clean TLP
        vecs.push_back(mk(H,H,L,L,4'h1,L, A,b(0)|b(8),Z,Z,Z,Z,         4'h1,L,H,H,16'd2)); // start in TLP
        vecs.push_back(mk(H,H,L,L,4'h1,L, A,Z,b(0),Z,Z,Z,              4'h1,L,H,H,16'd3)); // tracker was cleared
        vecs.push_back(mk(H,H,L,L,4'h1,L, A,b(1),Z,Z,Z,b(4),           4'h1,L,H,H,16'd4)); // dllpend no DLLP
        vecs.push_back(mk(H,H,L,L,4'h1,L, A,b(0),Z,b(7),Z,Z,           4'h1,L,H,L,16'd4)); // edb closes TLP
        vecs.push_back(mk(H,H,L,L,4'h1,L, A,b(4),Z,Z,b(0),Z,           4'h1,L,H,H,16'd5)); // start in DLLP
        vecs.push_back(mk(H,H,L,H,4'h1,L, A,Z,Z,Z,Z,Z,                 4'h1,H,H,L,16'd5)); // speed_change
        vecs.push_back(mk(H,H,L,L,4'h1,L, A,Z,Z,Z,Z,Z,                 4'h1,H,H,L,16'd5));
        vecs.push_back(mk(H,H,L,H,4'h1,L, A,Z,Z,Z,Z,Z,                 4'h1,H,H,L,16'd5)); // sc ignored in STALL
        vecs.push_back(mk(H,H,L,L,4'h1,H, A,Z,Z,Z,Z,Z,                 4'hB,H,L,L,16'd5)); // stallack
        vecs.push_back(mk(H,L,H,H,4'h1,L, A,Z,Z,Z,Z,Z,                 4'hB,H,L,L,16'd5)); // in recovery
        vecs.push_back(mk(H,H,H,L,4'h1,L, A,Z,Z,Z,Z,Z,                 4'hB,H,L,L,16'd5)); // l0 but recov
        vecs.push_back(mk(H,H,L,L,4'h1,L, A,Z,Z,Z,Z,Z,                 4'h1,L,H,L,16'd5)); // retrain done
        vecs.push_back(mk(H,H,H,L,4'h1,L, A,Z,Z,Z,Z,Z,                 4'h1,H,H,L,16'd5)); // recov -> STALL
        vecs.push_back(mk(H,H,H,L,4'h1,H, A,Z,Z,Z,Z,Z,                 4'hB,H,L,L,16'd5));
        vecs.push_back(mk(H,H,L,L,4'h1,L, A,Z,Z,Z,Z,Z,                 4'h1,L,H,L,16'd5));

        // Reset state, held with ACTIVE request present
        reset = 1'b0;
        idle_in();
        tick();
        chk_all(0, 4'h0, L, L, L, 16'd0);
        tick();
        chk_all(0, 4'h0, L, L, L, 16'd0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            tick();
            chk_all(i + 1, vecs[i].s, vecs[i].st, vecs[i].g, vecs[i].er, vecs[i].c);
        end

        // Stall timeout: no ack for STALL_TMO cycles, LINKERROR on the next
        idle_in();
        speed_change = 1'b1;
        tick();
        speed_change = 1'b0;
        chk_all(200, 4'h1, H, H, L, 16'd5);
        repeat (STALL_TMO - 1) tick();
        chk_all(201, 4'h1, H, H, L, 16'd5);
        tick();
        chk("pl_state_sts", 202, {12'h0, pl_state_sts}, 16'h000A);
        chk("rx_gate_en",   202, {15'h0, rx_gate_en},   16'h0000);
        chk("err_count",    202, err_count,             16'd5);
        lp_state_req = 4'h0;
        tick();
        chk_all(203, 4'h0, L, L, L, 16'd0);
        lp_state_req = 4'h1;
        tick();
        chk_all(204, 4'h1, L, H, L, 16'd0);

        // Link loss mid-packet during STALL
        rx_tlpstart = b(0);
        tick();
        rx_tlpstart = Z;
        chk_all(300, 4'h1, L, H, L, 16'd0);
        speed_change = 1'b1;
        tick();
        speed_change = 1'b0;
        chk_all(301, 4'h1, H, H, L, 16'd0);
        link_up = 1'b0;
        ltssm_l0 = 1'b0;
        tick();
        chk_all(302, 4'h0, L, L, L, 16'd0);
        link_up = 1'b1;
        ltssm_l0 = 1'b1;
        tick();
        chk_all(303, 4'h1, L, H, L, 16'd0);
        rx_tlpstart = b(0);
        tick();
        rx_tlpstart = Z;
        chk_all(304, 4'h1, L, H, L, 16'd0);
        rx_tlpend = b(3);
        tick();
        chk_all(305, 4'h1, L, H, L, 16'd0);
        tick();
        rx_tlpend = Z;
        chk_all(306, 4'h1, L, H, H, 16'd1);

        // Asynchronous reset mid-packet and mid-stall
        rx_tlpstart = b(0);
        tick();
        rx_tlpstart = Z;
        chk_all(400, 4'h1, L, H, L, 16'd1);
        speed_change = 1'b1;
        tick();
        speed_change = 1'b0;
        chk_all(401, 4'h1, H, H, L, 16'd1);
        #2;
        reset = 1'b0;
        #1;
        chk_all(402, 4'h0, L, L, L, 16'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk_all(403, 4'h1, L, H, L, 16'd0);
        rx_tlpstart = b(0);
        tick();
        rx_tlpstart = Z;
        chk_all(404, 4'h1, L, H, L, 16'd0);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
